// File: rtl/proposed_bka_array.sv
// Weight-stationary SIZE x SIZE signed 8-bit MAC array: product, Brent-Kung column tree, accumulate.
// Latency 3 edges from activation sample to result; no backpressure, preclk loads weights and clears the pipe.
module proposed_bka_array #(
  parameter int SIZE = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       preclk,
  input  logic [8*SIZE-1:0]          weight_in,
  input  logic [8*SIZE-1:0]          in_in,
  output logic [SIZE*(SIZE+16)-1:0]  result
);

  localparam int RW   = SIZE + 16;
  localparam int LVL  = $clog2(SIZE);
  localparam int TOPD = 1 << ($clog2(RW) - 1);

  // Brent-Kung prefix adder: up-sweep builds power-of-two group generates,
  // down-sweep fills in the remaining carry positions.
  function automatic logic [RW-1:0] bk_add(input logic [RW-1:0] x, input logic [RW-1:0] y);
    logic [RW-1:0] g;
    logic [RW-1:0] p;
    logic [RW-1:0] hs;
    g  = x & y;
    p  = x ^ y;
    hs = p;
    for (int d = 1; d < RW; d = d * 2) begin
      for (int i = 2 * d - 1; i < RW; i = i + 2 * d) begin
        g[i] = g[i] | (p[i] & g[i-d]);
        p[i] = p[i] & p[i-d];
      end
    end
    for (int d = TOPD; d >= 1; d = d / 2) begin
      for (int i = 3 * d - 1; i < RW; i = i + 2 * d) begin
        g[i] = g[i] | (p[i] & g[i-d]);
      end
    end
    return hs ^ {g[RW-2:0], 1'b0};
  endfunction

  function automatic logic [RW-1:0] col_sum(input logic [16*SIZE-1:0] pc);
    logic [RW-1:0] v [SIZE];
    for (int j = 0; j < SIZE; j++) begin
      v[j] = {{SIZE{pc[16*j+15]}}, pc[16*j +: 16]};
    end
    for (int l = 0; l < LVL; l++) begin
      for (int i = 0; i + (1 << l) < SIZE; i = i + (2 << l)) begin
        v[i] = bk_add(v[i], v[i + (1 << l)]);
      end
    end
    return v[0];
  endfunction

  function automatic logic [15:0] mul8(input logic [7:0] x, input logic [7:0] y);
    logic signed [15:0] xs;
    logic signed [15:0] ys;
    xs = {{8{x[7]}}, x};
    ys = {{8{y[7]}}, y};
    return xs * ys;
  endfunction

  logic [7:0]         w [SIZE][SIZE];
  logic [16*SIZE-1:0] p [SIZE];
  logic [RW-1:0]      s [SIZE];
  logic [RW-1:0]      a [SIZE];

  // p[k] holds the SIZE row products feeding column k, row j at [16j+:16].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SIZE; k++) begin
        for (int j = 0; j < SIZE; j++) begin
          w[j][k] <= '0;
        end
        p[k] <= '0;
        s[k] <= '0;
        a[k] <= '0;
      end
    end else if (preclk) begin
      for (int j = 0; j < SIZE; j++) begin
        w[j][0] <= weight_in[8*j +: 8];
        for (int k = 1; k < SIZE; k++) begin
          w[j][k] <= w[j][k-1];
        end
      end
      for (int k = 0; k < SIZE; k++) begin
        p[k] <= '0;
        s[k] <= '0;
        a[k] <= '0;
      end
    end else begin
      for (int k = 0; k < SIZE; k++) begin
        for (int j = 0; j < SIZE; j++) begin
          p[k][16*j +: 16] <= mul8(in_in[8*j +: 8], w[j][k]);
        end
        s[k] <= col_sum(p[k]);
        a[k] <= bk_add(a[k], s[k]);
      end
    end
  end

  for (genvar k = 0; k < SIZE; k++) begin : g_res
    assign result[RW*k +: RW] = a[k];
  end

endmodule

// File: tb/tb_proposed_bka_array.sv
// Scoreboard bench for proposed_bka_array at SIZE=4: stimulus pushes expected results, a monitor pops them.
module tb_proposed_bka_array;

  localparam int SIZE = 4;
  localparam int RW   = SIZE + 16;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  preclk = 1'b0;
  logic [8*SIZE-1:0]     weight_in = '0;
  logic [8*SIZE-1:0]     in_in = '0;
  logic [SIZE*RW-1:0]    result;

  always #5 clk = ~clk;

  proposed_bka_array #(.SIZE(SIZE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .preclk    (preclk),
    .weight_in (weight_in),
    .in_in     (in_in),
    .result    (result)
  );

  typedef struct {
    int                 due;
    logic [SIZE*RW-1:0] val;
  } exp_t;

  exp_t          sb [$];
  exp_t          mon_e;
  int            cyc = 0;
  int            tests = 0;
  int            fails = 0;
  logic [7:0]    row_q [SIZE][$];
  logic [RW-1:0] acc [SIZE];

  always @(posedge clk) cyc <= cyc + 1;

  // Checks every expectation whose edge has passed; sampled on the falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      tests++;
      if (result !== mon_e.val) begin
        fails++;
        $display("FAIL result@edge%0d got=%h exp=%h", mon_e.due, result, mon_e.val);
      end
    end
  end

  function automatic logic [SIZE*RW-1:0] acc_vec();
    logic [SIZE*RW-1:0] v;
    for (int k = 0; k < SIZE; k++) v[RW*k +: RW] = acc[k];
    return v;
  endfunction

  function automatic void push(input int due, input logic [SIZE*RW-1:0] v);
    exp_t e;
    e.due = due;
    e.val = v;
    sb.push_back(e);
  endfunction

  task automatic model_clear();
    for (int j = 0; j < SIZE; j++) begin
      row_q[j].delete();
      repeat (SIZE) row_q[j].push_back(8'd0);
    end
    for (int k = 0; k < SIZE; k++) acc[k] = '0;
  endtask

  // One clock edge. A load edge prepends the new byte to each row list (column 0 is newest)
  // and voids any result still in flight; a stream edge adds the dot products SIZE..
  task automatic do_edge(input bit ld, input logic [8*SIZE-1:0] wv, input logic [8*SIZE-1:0] iv);
    int n;
    int d;
    n = cyc + 1;
    preclk    = ld;
    weight_in = wv;
    in_in     = iv;
    if (ld) begin
      for (int j = 0; j < SIZE; j++) begin
        row_q[j].push_front(wv[8*j +: 8]);
        void'(row_q[j].pop_back());
      end
      for (int k = 0; k < SIZE; k++) acc[k] = '0;
      while (sb.size() > 0 && sb[$].due >= n) void'(sb.pop_back());
      push(n, '0);
    end else begin
      for (int k = 0; k < SIZE; k++) begin
        d = 0;
        for (int j = 0; j < SIZE; j++) d += $signed(iv[8*j +: 8]) * $signed(row_q[j][k]);
        acc[k] = acc[k] + d[RW-1:0];
      end
      push(n + 2, acc_vec());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_all(input logic [8*SIZE-1:0] wv);
    repeat (SIZE) do_edge(1'b1, wv, $urandom());
  endtask

  task automatic zeros(input int cnt);
    repeat (cnt) do_edge(1'b0, '0, '0);
  endtask

  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    sb.delete();
    model_clear();
    push(cyc, '0);
    do_edge(1'b0, '0, $urandom());
    do_edge(1'b0, '0, $urandom());
    rst_n = 1'b1;
  endtask

  initial begin
    model_clear();
    push(0, '0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // load order: bytes 4,3,2,1 give W[j][k] = k+1
    for (int b = 4; b >= 1; b--) do_edge(1'b1, {4{8'(b)}}, $urandom());
    do_edge(1'b0, '0, 32'h01010101);
    zeros(4);

    load_all({4{8'd127}});
    do_edge(1'b0, '0, 32'h80808080);
    zeros(3);
    load_all({4{8'h80}});
    do_edge(1'b0, '0, 32'h80808080);
    zeros(3);

    load_all({4{8'd1}});
    do_edge(1'b0, '0, 32'h01010101);
    do_edge(1'b0, '0, 32'h02020202);
    do_edge(1'b0, '0, 32'h03030303);
    zeros(3);

    load_all($urandom());
    repeat (5) do_edge(1'b0, '0, $urandom());
    repeat (SIZE) do_edge(1'b1, $urandom(), $urandom());
    repeat (5) do_edge(1'b0, '0, $urandom());
    zeros(3);

    load_all({4{8'h80}});
    repeat (16) do_edge(1'b0, '0, 32'h80808080);
    zeros(3);

    load_all($urandom());
    repeat (3) do_edge(1'b0, '0, $urandom());
    do_reset();
    repeat (4) do_edge(1'b0, '0, $urandom());

    // random loads with occasional gaps, then random-length streams
    repeat (20) begin
      for (int m = 0; m < SIZE; m++) begin
        if ($urandom_range(0, 3) == 0) do_edge(1'b0, '0, $urandom());
        do_edge(1'b1, $urandom(), $urandom());
      end
      repeat ($urandom_range(3, 12)) begin
        if ($urandom_range(0, 4) == 0) do_edge(1'b0, '0, '0);
        else do_edge(1'b0, '0, $urandom());
      end
    end
    zeros(3);

    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      @(negedge clk); #1;
    end
    if (sb.size() > 0) begin
      $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
      $fatal(1, "scoreboard did not drain");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
